// File: rtl/fib_dispatcher.sv
// fib_dispatcher: queues Fibonacci index requests and feeds them one at a
// time to the engine over its level-held start/done handshake, returning
// each result tagged with its index on a valid/ready response port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no job outstanding; pops the FIFO head when one is queued
// ISSUE   | start raised for one cycle; engine done may be stale, ignored
// WAIT    | start held; waiting for engine done or for the timeout
// RELEASE | start dropped; response held until the consumer accepts it
// HALT    | engine presumed hung; error response delivered, reset only exit
module fib_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 70000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [15:0]                req_n,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [15:0]                rsp_n,
    output logic [15:0]                rsp_fib,
    output logic                       rsp_err,
    output logic                       fib_start,
    output logic [15:0]                fib_din,
    input  logic [15:0]                fib_dout,
    input  logic                       fib_done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    // The timer counts down from TIMEOUT-1; reaching zero in WAIT is the
    // same cycle an up-counter would hit TIMEOUT-1.
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_HALT
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [15:0]   head;

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          fib_start_nxt;
    logic [15:0]   fib_din_nxt;
    logic [15:0]   rsp_n_nxt;
    logic [15:0]   rsp_fib_nxt;
    logic          rsp_err_nxt;
    logic          rsp_valid_nxt;

    // A full FIFO refuses pushes even in a cycle that also pops.
    assign req_ready = (fifo_count < FULL_COUNT);
    assign push      = req_valid && req_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != S_IDLE);

    // Request storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_n;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register plus every registered engine and response output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            fib_start <= 1'b0;
            fib_din   <= '0;
            rsp_n     <= '0;
            rsp_fib   <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            fib_start <= fib_start_nxt;
            fib_din   <= fib_din_nxt;
            rsp_n     <= rsp_n_nxt;
            rsp_fib   <= rsp_fib_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_valid <= rsp_valid_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        timer_nxt     = timer;
        fib_start_nxt = fib_start;
        fib_din_nxt   = fib_din;
        rsp_n_nxt     = rsp_n;
        rsp_fib_nxt   = rsp_fib;
        rsp_err_nxt   = rsp_err;
        rsp_valid_nxt = rsp_valid;

        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop           = 1'b1;
                    fib_din_nxt   = head;
                    rsp_n_nxt     = head;
                    fib_start_nxt = 1'b1;
                    timer_nxt     = TIMER_LOAD;
                    state_nxt     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // done here can be left over from the previous job; the
                // engine only clears it once it has seen the new start.
                fib_start_nxt = 1'b1;
                state_nxt     = S_WAIT;
            end

            S_WAIT: begin
                fib_start_nxt = 1'b1;
                if (fib_done) begin
                    rsp_fib_nxt   = fib_dout;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = S_RELEASE;
                end else if (timer == '0) begin
                    rsp_fib_nxt   = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = S_HALT;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end

            S_RELEASE: begin
                // Dropping start here guarantees at least one low cycle so
                // the engine returns to idle before the next issue.
                fib_start_nxt = 1'b0;
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end

            S_HALT: begin
                // A hung engine cannot be aborted; a late done would land on
                // a later job, so nothing more is issued until reset.
                fib_start_nxt = 1'b0;
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fib_dispatcher.sv
// Directed bench for fib_dispatcher: a nominal engine model drives the main
// instance; a second instance with a short timeout faces a silent engine.
module tb_fib_dispatcher;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic        fib_start, fib_done, busy;
    logic [15:0] req_n, rsp_n, rsp_fib, fib_din, fib_dout;
    logic [2:0]  fifo_count;

    logic        to_req_valid, to_req_ready, to_rsp_valid, to_rsp_ready, to_rsp_err;
    logic        to_fib_start, to_fib_done, to_busy;
    logic [15:0] to_req_n, to_rsp_n, to_rsp_fib, to_fib_din, to_fib_dout;
    logic [2:0]  to_fifo_count;

    int checks = 0;
    int errors = 0;

    fib_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(70000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_n      (req_n),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_n      (rsp_n),
        .rsp_fib    (rsp_fib),
        .rsp_err    (rsp_err),
        .fib_start  (fib_start),
        .fib_din    (fib_din),
        .fib_dout   (fib_dout),
        .fib_done   (fib_done),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    fib_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(8)) dut_to (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (to_req_valid),
        .req_ready  (to_req_ready),
        .req_n      (to_req_n),
        .rsp_valid  (to_rsp_valid),
        .rsp_ready  (to_rsp_ready),
        .rsp_n      (to_rsp_n),
        .rsp_fib    (to_rsp_fib),
        .rsp_err    (to_rsp_err),
        .fib_start  (to_fib_start),
        .fib_din    (to_fib_din),
        .fib_dout   (to_fib_dout),
        .fib_done   (to_fib_done),
        .busy       (to_busy),
        .fifo_count (to_fifo_count)
    );

    // The hung engine never finishes; its dout carries junk that must not leak.
    assign to_fib_done = 1'b0;
    assign to_fib_dout = 16'hBEEF;

    // Nominal engine: registers start, answers n<2 immediately, otherwise
    // iterates n-1 times; done stays high until start has been seen low.
    logic [1:0]  eng_st;
    logic        eng_start_q;
    logic [15:0] ea, eb, ek;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_st      <= 2'd0;
            eng_start_q <= 1'b0;
            ea          <= '0;
            eb          <= '0;
            ek          <= '0;
            fib_done    <= 1'b0;
            fib_dout    <= '0;
        end else begin
            eng_start_q <= fib_start;
            case (eng_st)
                2'd0: if (eng_start_q) begin
                    if (fib_din < 16'd2) begin
                        fib_done <= 1'b1;
                        fib_dout <= fib_din;
                        eng_st   <= 2'd2;
                    end else begin
                        ea     <= 16'd0;
                        eb     <= 16'd1;
                        ek     <= fib_din - 16'd1;
                        eng_st <= 2'd1;
                    end
                end
                2'd1: if (ek == 16'd0) begin
                    fib_done <= 1'b1;
                    fib_dout <= eb;
                    eng_st   <= 2'd2;
                end else begin
                    ea <= eb;
                    eb <= ea + eb;
                    ek <= ek - 16'd1;
                end
                default: if (!eng_start_q) begin
                    fib_done <= 1'b0;
                    eng_st   <= 2'd0;
                end
            endcase
        end
    end

    function automatic logic [15:0] fib_ref(input logic [15:0] n);
        logic [15:0] a, b, t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic test_reset();
        req_valid = 1'b0; req_n = '0; rsp_ready = 1'b0;
        to_req_valid = 1'b0; to_req_n = '0; to_rsp_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_n !== 16'd0 || rsp_fib !== 16'd0 || rsp_err !== 1'b0 ||
            fib_start !== 1'b0 || fib_din !== 16'd0 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b n=%0d fib=%0d err=%b start=%b din=%0d busy=%b cnt=%0d, expected all 0",
                     rsp_valid, rsp_n, rsp_fib, rsp_err, fib_start, fib_din, busy, fifo_count);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int k;
        rsp_ready = 1'b1;
        req_n = 16'd10; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1 || fib_start !== 1'b0) begin
            errors++;
            $display("FAIL single_push: got cnt=%0d start=%b expected cnt=1 start=0", fifo_count, fib_start);
        end
        @(negedge clk);
        checks++;
        if (fib_start !== 1'b1 || fib_din !== 16'd10 || fifo_count !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got start=%b din=%0d cnt=%0d busy=%b expected 1/10/0/1",
                     fib_start, fib_din, fifo_count, busy);
        end
        k = 1;
        while (rsp_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 14) begin
            errors++;
            $display("FAIL single_latency: got edge %0d expected 14", k);
        end
        checks++;
        if (rsp_n !== 16'd10 || rsp_fib !== 16'd55 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got n=%0d fib=%0d err=%b expected 10/55/0", rsp_n, rsp_fib, rsp_err);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || fib_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got v=%b start=%b busy=%b expected 0/0/0", rsp_valid, fib_start, busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ns [4];
        logic [15:0] ef [4];
        int got, cyc;
        ns = '{16'd0, 16'd1, 16'd2, 16'd5};
        ef = '{16'd0, 16'd1, 16'd1, 16'd5};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_n = ns[i];
            @(negedge clk);
        end
        req_valid = 1'b0;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_n !== ns[got] || rsp_fib !== ef[got] || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: got n=%0d fib=%0d err=%b expected %0d/%0d/0",
                             got, rsp_n, rsp_fib, rsp_err, ns[got], ef[got]);
                end
                got++;
                @(negedge clk);
                cyc++;
                checks++;
                if (fib_start !== 1'b0 || rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap_low: got start=%b v=%b expected 0/0", fib_start, rsp_valid);
                end
                if (got < 4) begin
                    @(negedge clk);
                    cyc++;
                    checks++;
                    if (fib_start !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_gap_one: got start=%b expected 1", fib_start);
                    end
                end
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses expected 4", got);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [6];
        logic [15:0] ef [5];
        logic [15:0] cap_n, cap_f;
        logic        will, stable;
        int sent, k, got, cyc;
        vals = '{16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9};
        ef   = '{16'd2, 16'd3, 16'd8, 16'd13, 16'd21};
        rsp_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1;
            req_n = vals[sent];
            will = req_ready;
            @(negedge clk);
            if (will) sent++;
            if (sent > 5) break;
        end
        req_valid = 1'b0;
        checks++;
        if (sent != 5 || req_ready !== 1'b0 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_full: got accepted=%0d ready=%b cnt=%0d expected 5/0/4", sent, req_ready, fifo_count);
        end
        k = 0;
        while (rsp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_n !== 16'd3 || rsp_fib !== 16'd2) begin
            errors++;
            $display("FAIL bp_first: got v=%b n=%0d fib=%0d expected 1/3/2", rsp_valid, rsp_n, rsp_fib);
        end
        cap_n = rsp_n;
        cap_f = rsp_fib;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_n !== cap_n || rsp_fib !== cap_f || rsp_err !== 1'b0 ||
                fifo_count !== 3'd4 || fib_start !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: got v=%b n=%0d fib=%0d cnt=%0d start=%b expected 1/3/2/4/0",
                     rsp_valid, rsp_n, rsp_fib, fifo_count, fib_start);
        end
        rsp_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 300) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_n !== vals[got] || rsp_fib !== ef[got] || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_rsp%0d: got n=%0d fib=%0d expected %0d/%0d",
                             got, rsp_n, rsp_fib, vals[got], ef[got]);
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (got != 5 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bp_drain: got %0d responses cnt=%0d expected 5/0", got, fifo_count);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_simul_push_pop();
        logic [15:0] en [$];
        logic [15:0] vals [4];
        logic [15:0] e;
        int  got, cyc;
        logic did_push;
        vals = '{16'd6, 16'd4, 16'd3, 16'd5};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_n = vals[i];
            en.push_back(vals[i]);
            @(negedge clk);
        end
        req_valid = 1'b0;
        got = 0;
        cyc = 0;
        did_push = 1'b0;
        while (got < 4 && cyc < 300) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (en.size() == 0) begin
                    errors++;
                    $display("FAIL spp_extra: got n=%0d with nothing outstanding", rsp_n);
                end else begin
                    e = en.pop_front();
                    if (rsp_n !== e || rsp_fib !== fib_ref(e) || rsp_err !== 1'b0) begin
                        errors++;
                        $display("FAIL spp_rsp: got n=%0d fib=%0d expected %0d/%0d", rsp_n, rsp_fib, e, fib_ref(e));
                    end
                end
                got++;
            end
            if (!did_push && busy === 1'b0 && fifo_count === 3'd2) begin
                req_valid = 1'b1;
                req_n = vals[3];
                en.push_back(vals[3]);
                did_push = 1'b1;
                @(negedge clk);
                cyc++;
                req_valid = 1'b0;
                checks++;
                if (fifo_count !== 3'd2 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL spp_count: got cnt=%0d busy=%b expected 2/1", fifo_count, busy);
                end
                continue;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (got != 4 || did_push !== 1'b1) begin
            errors++;
            $display("FAIL spp_done: got %0d responses push=%b expected 4/1", got, did_push);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [15:0] en [$];
        logic [15:0] e;
        int pushed, got, cyc;
        rsp_ready = 1'b1;
        pushed = 0;
        got = 0;
        cyc = 0;
        while (got < 3 * DEPTH && cyc < 2000) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (en.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_extra: got n=%0d with nothing outstanding", rsp_n);
                end else begin
                    e = en.pop_front();
                    if (rsp_n !== e || rsp_fib !== fib_ref(e) || rsp_err !== 1'b0) begin
                        errors++;
                        $display("FAIL wrap_rsp%0d: got n=%0d fib=%0d expected %0d/%0d",
                                 got, rsp_n, rsp_fib, e, fib_ref(e));
                    end
                end
                got++;
            end
            if (pushed < 3 * DEPTH && req_ready === 1'b1) begin
                req_valid = 1'b1;
                req_n = 16'((pushed * 5) % 13);
                en.push_back(req_n);
                pushed++;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        checks++;
        if (got != 3 * DEPTH || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_count: got %0d responses cnt=%0d expected %0d/0", got, fifo_count, 3 * DEPTH);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        int k;
        logic stable;
        to_rsp_ready = 1'b0;
        to_req_n = 16'd4;
        to_req_valid = 1'b1;
        @(negedge clk);
        to_req_valid = 1'b0;
        k = 0;
        while (to_rsp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 10) begin
            errors++;
            $display("FAIL timeout_latency: got edge %0d expected 10", k);
        end
        checks++;
        if (to_rsp_err !== 1'b1 || to_rsp_fib !== 16'd0 || to_rsp_n !== 16'd4) begin
            errors++;
            $display("FAIL timeout_rsp: got err=%b fib=%0d n=%0d expected 1/0/4", to_rsp_err, to_rsp_fib, to_rsp_n);
        end
        @(negedge clk);
        checks++;
        if (to_fib_start !== 1'b0 || to_busy !== 1'b1) begin
            errors++;
            $display("FAIL halt_start: got start=%b busy=%b expected 0/1", to_fib_start, to_busy);
        end
        for (int i = 0; i < 2; i++) begin
            to_req_valid = 1'b1;
            to_req_n = 16'(20 + i);
            @(negedge clk);
        end
        to_req_valid = 1'b0;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (to_fib_start !== 1'b0 || to_fifo_count !== 3'd2 || to_fib_din !== 16'd4 ||
                to_rsp_valid !== 1'b1 || to_rsp_err !== 1'b1)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold: got start=%b cnt=%0d din=%0d v=%b err=%b expected 0/2/4/1/1",
                     to_fib_start, to_fifo_count, to_fib_din, to_rsp_valid, to_rsp_err);
        end
        to_rsp_ready = 1'b1;
        @(negedge clk);
        to_rsp_ready = 1'b0;
        checks++;
        if (to_rsp_valid !== 1'b0 || to_busy !== 1'b1) begin
            errors++;
            $display("FAIL halt_rsp_taken: got v=%b busy=%b expected 0/1", to_rsp_valid, to_busy);
        end
        for (int i = 0; i < 3; i++) begin
            to_req_valid = 1'b1;
            to_req_n = 16'(30 + i);
            @(negedge clk);
        end
        to_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (to_fifo_count !== 3'd4 || to_req_ready !== 1'b0 || to_fib_start !== 1'b0 || to_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_full: got cnt=%0d ready=%b start=%b v=%b expected 4/0/0/0",
                     to_fifo_count, to_req_ready, to_fib_start, to_rsp_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [15:0] ns [4];
        int k;
        ns = '{16'd12, 16'd1, 16'd2, 16'd3};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_n = ns[i];
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fifo_count !== 3'd3 || fib_start !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: got busy=%b cnt=%0d start=%b v=%b expected 1/3/1/0",
                     busy, fifo_count, fib_start, rsp_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_n !== 16'd0 || rsp_fib !== 16'd0 || rsp_err !== 1'b0 ||
            fib_start !== 1'b0 || fib_din !== 16'd0 || busy !== 1'b0 || fifo_count !== 3'd0 ||
            req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: got v=%b n=%0d fib=%0d err=%b start=%b din=%0d busy=%b cnt=%0d ready=%b expected zeros, ready=1",
                     rsp_valid, rsp_n, rsp_fib, rsp_err, fib_start, fib_din, busy, fifo_count, req_ready);
        end
        checks++;
        if (to_fifo_count !== 3'd0 || to_busy !== 1'b0 || to_rsp_valid !== 1'b0 || to_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_halt_exit: got cnt=%0d busy=%b v=%b ready=%b expected 0/0/0/1",
                     to_fifo_count, to_busy, to_rsp_valid, to_req_ready);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        req_n = 16'd7;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 11 || rsp_n !== 16'd7 || rsp_fib !== 16'd13 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got edge=%0d n=%0d fib=%0d err=%b expected 11/7/13/0", k, rsp_n, rsp_fib, rsp_err);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_simul_push_pop();
        test_wrap();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
